// File: rtl/instr_fetch_sequencer.sv
// instr_fetch_sequencer: program sequencer feeding the 8-bit control unit.
// Holds a writable instruction memory, steps a program counter and issues one
// instruction at a time over a valid/ready handshake. Opcode 4'hF halts.
// Optional feature macro: INSTR_FETCH_JUMP_EN. When it is defined, opcode 4'hE
// is a local jump (pc <= low bits of the word) and is never issued.
//
// Handshake: instr_valid rises with instruction when a word leaves FETCH; both
// hold stable until a rising edge with ctrl_ready=1, which completes the
// transfer. instr_valid only drops on a handshake or on reset.
module instr_fetch_sequencer #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [7:0]        load_data,
  input  logic              start,
  input  logic              ctrl_ready,
  output logic [7:0]        instruction,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [7:0]        mem [DEPTH];
  logic [7:0]        fetch_word;
  logic [ADDR_W-1:0] pc_next;
  logic [7:0]        instr_next;
  logic              valid_next;
  logic              mem_we;

  assign fetch_word = mem[pc];

  // Next-state, next-pc and issue decode; writes only allowed while parked.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    instr_next = instruction;
    valid_next = instr_valid;
    mem_we     = 1'b0;
    case (state)
      IDLE, HALT: begin
        mem_we = load_en;
        if (start) begin
          pc_next    = '0;
          state_next = FETCH;
        end
      end
      FETCH: begin
        if (fetch_word[7:4] == 4'hF) begin
          state_next = HALT;
        end
`ifdef INSTR_FETCH_JUMP_EN
        else if (fetch_word[7:4] == 4'hE) begin
          pc_next = fetch_word[ADDR_W-1:0];
        end
`endif
        else begin
          instr_next = fetch_word;
          valid_next = 1'b1;
          pc_next    = pc + 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (ctrl_ready) begin
          valid_next = 1'b0;
          state_next = FETCH;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State and output registers; memory contents survive reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= '0;
      instruction <= 8'h00;
      instr_valid <= 1'b0;
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      instruction <= instr_next;
      instr_valid <= valid_next;
    end
  end

  // Instruction memory write port (no reset on the array).
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[load_addr] <= load_data;
    end
  end

  // Status flags are pure decodes of the registered state.
  always_comb begin
    busy   = (state == FETCH) || (state == ISSUE);
    halted = (state == HALT);
  end

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// Testbench for instr_fetch_sequencer (default ADDR_W=4).
module tb_instr_fetch_sequencer;

  localparam int ADDR_W = 4;

  logic              clk;
  logic              rst_n;
  logic              load_en;
  logic [ADDR_W-1:0] load_addr;
  logic [7:0]        load_data;
  logic              start;
  logic              ctrl_ready;
  logic [7:0]        instruction;
  logic              instr_valid;
  logic [ADDR_W-1:0] pc;
  logic              busy;
  logic              halted;

  int tests_run    = 0;
  int tests_failed = 0;
  logic [7:0] exp_q[$];
  logic       prev_stall;
  logic       wrap_seen;
  logic [ADDR_W-1:0] prev_pc;

  instr_fetch_sequencer #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .start(start), .ctrl_ready(ctrl_ready),
    .instruction(instruction), .instr_valid(instr_valid), .pc(pc),
    .busy(busy), .halted(halted)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle: check handshake at negedge, then step past the rising edge.
  task automatic tick();
    logic [7:0] exp;
    @(negedge clk);
    if (rst_n && prev_stall) begin
      tests_run++;
      if (instr_valid !== 1'b1 || instruction !== exp_q[0]) begin
        tests_failed++;
        $display("FAIL hold_stable: valid=%b instr=%h required valid=1 instr=%h",
                 instr_valid, instruction, exp_q.size() > 0 ? exp_q[0] : 8'hxx);
      end
    end
    if (instr_valid === 1'b1 && ctrl_ready === 1'b1) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL unexpected_issue: instr=%h issued, required none", instruction);
      end else begin
        exp = exp_q.pop_front();
        if (instruction !== exp) begin
          tests_failed++;
          $display("FAIL issue_data: instr=%h required %h", instruction, exp);
        end
      end
    end
    prev_stall = instr_valid && !ctrl_ready && exp_q.size() > 0;
    prev_pc = pc;
    @(posedge clk);
    #1;
    if (prev_pc == 4'd15 && pc == 4'd0) wrap_seen = 1'b1;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0; load_en = 1'b0; load_addr = '0; load_data = 8'h00;
    start = 1'b0; ctrl_ready = 1'b0; prev_stall = 1'b0; wrap_seen = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic load_word(input logic [ADDR_W-1:0] a, input logic [7:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    tick();
    load_en = 1'b0;
  endtask

  task automatic start_prog();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_until_halt(input int max_cycles, input bit rand_ready);
    int n = 0;
    while (!halted && n < max_cycles) begin
      if (rand_ready) ctrl_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    tests_run++;
    if (halted !== 1'b1 || exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL run_to_halt: halted=%b pending=%0d required halted=1 pending=0",
               halted, exp_q.size());
    end
  endtask

  task automatic check_outputs(input string name, input logic [7:0] e_instr,
                               input logic e_valid, input logic [ADDR_W-1:0] e_pc,
                               input logic e_busy, input logic e_halted);
    tests_run++;
    if (instruction !== e_instr || instr_valid !== e_valid || pc !== e_pc ||
        busy !== e_busy || halted !== e_halted) begin
      tests_failed++;
      $display("FAIL %s: instr=%h valid=%b pc=%0d busy=%b halted=%b required %h %b %0d %b %b",
               name, instruction, instr_valid, pc, busy, halted,
               e_instr, e_valid, e_pc, e_busy, e_halted);
    end
  endtask

  task automatic load_basic();
    load_word(0, 8'h00);
    load_word(1, 8'h15);
    load_word(2, 8'hF0);
  endtask

  task automatic test_reset();
    reset_dut();
    check_outputs("reset", 8'h00, 1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_basic();
    load_basic();
    ctrl_ready = 1'b1;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h15);
    start_prog();
    check_outputs("after_start", 8'h00, 1'b0, 0, 1'b1, 1'b0);
    tick();
    check_outputs("first_valid", 8'h00, 1'b1, 1, 1'b1, 1'b0);
    run_until_halt(20, 1'b0);
    check_outputs("basic_halt", 8'h15, 1'b0, 2, 1'b0, 1'b1);
  endtask

  task automatic test_stall();
    ctrl_ready = 1'b0;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h15);
    start_prog();
    tick();
    for (int i = 0; i < 5; i++) begin
      check_outputs("stall_hold", 8'h00, 1'b1, 1, 1'b1, 1'b0);
      tick();
    end
    ctrl_ready = 1'b1;
    run_until_halt(20, 1'b0);
    check_outputs("stall_halt", 8'h15, 1'b0, 2, 1'b0, 1'b1);
  endtask

  task automatic test_jump();
    load_word(0, 8'hE3);
    load_word(3, 8'h20);
    load_word(4, 8'hF0);
    ctrl_ready = 1'b1;
`ifdef INSTR_FETCH_JUMP_EN
    exp_q.push_back(8'h20);
    start_prog();
    run_until_halt(20, 1'b0);
    check_outputs("jump_halt", 8'h20, 1'b0, 4, 1'b0, 1'b1);
`else
    exp_q.push_back(8'hE3);
    exp_q.push_back(8'h15);
    start_prog();
    run_until_halt(20, 1'b0);
    check_outputs("nojump_halt", 8'h15, 1'b0, 2, 1'b0, 1'b1);
`endif
  endtask

  task automatic test_random_ready();
    load_basic();
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h15);
    start_prog();
    run_until_halt(200, 1'b1);
    check_outputs("rand_halt", 8'h15, 1'b0, 2, 1'b0, 1'b1);
  endtask

  task automatic test_wrap();
    int n = 0;
    for (int i = 0; i < 16; i++) load_word(4'(i), 8'h01);
    ctrl_ready = 1'b1;
    wrap_seen = 1'b0;
    for (int i = 0; i < 20; i++) exp_q.push_back(8'h01);
    start_prog();
    while (exp_q.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    tests_run++;
    if (exp_q.size() != 0 || wrap_seen !== 1'b1 || halted !== 1'b0) begin
      tests_failed++;
      $display("FAIL wrap: pending=%0d wrap=%b halted=%b required 0 1 0",
               exp_q.size(), wrap_seen, halted);
    end
  endtask

  task automatic test_reset_mid();
    reset_dut();
    load_basic();
    exp_q.push_back(8'h00);
    start_prog();
    tick();
    check_outputs("issue_pre_reset", 8'h00, 1'b1, 1, 1'b1, 1'b0);
    exp_q.delete();
    prev_stall = 1'b0;
    rst_n = 1'b0;
    #1;
    check_outputs("async_reset", 8'h00, 1'b0, 0, 1'b0, 1'b0);
    tick();
    rst_n = 1'b1;
    ctrl_ready = 1'b1;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h15);
    start_prog();
    run_until_halt(20, 1'b0);
    check_outputs("rerun_halt", 8'h15, 1'b0, 2, 1'b0, 1'b1);
  endtask

  task automatic test_load_rules();
    ctrl_ready = 1'b0;
    exp_q.push_back(8'h00);
    start_prog();
    tick();
    load_en = 1'b1; load_addr = 0; load_data = 8'h77;
    start = 1'b1;
    tick();
    load_en = 1'b0; start = 1'b0;
    check_outputs("ignored_in_issue", 8'h00, 1'b1, 1, 1'b1, 1'b0);
    ctrl_ready = 1'b1;
    exp_q.push_back(8'h15);
    run_until_halt(20, 1'b0);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h15);
    start_prog();
    run_until_halt(20, 1'b0);
    exp_q.push_back(8'h33);
    exp_q.push_back(8'h15);
    load_en = 1'b1; load_addr = 0; load_data = 8'h33;
    start_prog();
    load_en = 1'b0;
    run_until_halt(20, 1'b0);
    check_outputs("load_start_halt", 8'h15, 1'b0, 2, 1'b0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_jump();
    test_random_ready();
    test_wrap();
    test_reset_mid();
    test_load_rules();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/instr_fetch_sequencer.md
# instr_fetch_sequencer

Program sequencer that sits directly upstream of the 8-bit control unit. It holds a small writable instruction memory, steps a program counter, and issues one 8-bit instruction at a time to the control unit over a valid/ready handshake. Two opcodes the control unit does not use are consumed locally: 4'b1111 halts and 4'b1110 jumps. Software preloads the program through a load port, then pulses `start`.

## Interface
- `ADDR_W`, 4: PC and memory address width; depth = 2**ADDR_W; legal 1..4.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `load_en` input 1: write strobe for instruction memory.
- `load_addr` input ADDR_W: write address.
- `load_data` input 8: instruction byte to write.
- `start` input 1: begin execution at PC 0.
- `ctrl_ready` input 1: control unit accepts the presented instruction.
- `instruction` output 8: instruction to control unit.
- `instr_valid` output 1: `instruction` is valid.
- `pc` output ADDR_W: address of the next word to fetch.
- `busy` output 1: high in FETCH or ISSUE.
- `halted` output 1: high in HALT.

## Operation
- Reset values: `instruction`=8'h00, `instr_valid`=0, `pc`=0, `busy`=0, `halted`=0, state=IDLE. The memory array is not reset.
- States: IDLE, FETCH, ISSUE, HALT.
- IDLE: `load_en` writes `mem[load_addr]`<=`load_data`. `start` sets `pc`<=0 and moves to FETCH.
- FETCH: decode `mem[pc]`.
  - Opcode [7:4]==4'b1111: go to HALT; `pc` unchanged.
  - Opcode 4'b1110 (jump): `pc`<=`mem[pc][ADDR_W-1:0]`; stay in FETCH. This applies only when the jump feature is compiled in (see Configuration).
  - Otherwise: `instruction`<=`mem[pc]`, `instr_valid`<=1, `pc`<=`pc`+1 mod 2**ADDR_W, go to ISSUE.
- ISSUE: `instruction` and `instr_valid` hold stable while `ctrl_ready`=0. On an edge with `ctrl_ready`=1: `instr_valid`<=0, go to FETCH.
- HALT: `load_en` writes as in IDLE. `start` sets `pc`<=0 and moves to FETCH.
- `load_en` in FETCH or ISSUE is ignored; no write occurs.
- `start` in FETCH or ISSUE is ignored.
- `load_en` and `start` together in IDLE or HALT: the write and the start both take effect at the same edge. The written word is visible to the first fetch.
- PC wraps from 2**ADDR_W-1 to 0 with no flag.
- A jump to its own address loops forever in FETCH. Only reset or a halt can end this.

## Timing
- `start` sampled at edge k: FETCH after edge k; the first `instr_valid`=1 appears after edge k+1.
- Issue latency is one cycle from FETCH. Each executed jump adds one cycle.
- Peak throughput: one instruction per 2 cycles when `ctrl_ready` is held high.
- `instr_valid` never drops without a handshake, except on reset.
- Asserting `rst_n` low mid-operation clears all outputs immediately and returns to IDLE. The memory keeps its contents.
- `busy` and `halted` are decoded from registered state, with no combinational path from inputs.

## Configuration
- `INSTR_FETCH_JUMP_EN` defined: opcode 4'b1110 is a local jump and is never issued.
- `INSTR_FETCH_JUMP_EN` undefined: opcode 4'b1110 is issued to the control unit like any other non-halt opcode. There is no jump logic.
- Halt decoding is always present.

## Test plan
- Load mem[0..2]=8'h00,8'h15,8'hF0; start; `ctrl_ready`=1 -> 8'h00 and 8'h15 issued on consecutive handshakes; `halted`=1 with `pc`=2; `instr_valid` never high for 8'hF0.
- Same program, `ctrl_ready`=0 for 5 cycles after first valid -> 8'h00 and `instr_valid`=1 held for 5 cycles; `pc`=1 throughout.
- Jump enabled: mem[0]=8'hE3, mem[3]=8'h20, mem[4]=8'hF0 -> only 8'h20 issued; `halted` with `pc`=4. Jump disabled: 8'hE3 issued first.
- Sixteen words of 8'h01 (no halt), `ctrl_ready`=1 -> `pc` wraps 15->0; issuing continues; `halted`=0.
- Pulse `rst_n` low while in ISSUE -> all outputs 0 immediately. Restart with `start` alone (no reload) -> the previous program runs again.
- `load_en` to addr 0 with 8'h77 during ISSUE -> mem[0] unchanged, verified on restart. `load_en` plus `start` together in HALT with addr 0 = 8'h33 -> first issued instruction is 8'h33.
